// File: rtl/drive_cmd_arbiter.sv
// Two-source drive command arbiter for the car motion controller.
// Safety has fixed priority and may preempt a remote command with BRAKE/STOP.
module drive_cmd_arbiter #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 2
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       rc_valid,
    input  logic [2:0] rc_cmd,
    output logic       rc_ready,
    input  logic       sf_valid,
    input  logic [2:0] sf_cmd,
    output logic       sf_ready,
    output logic       key,
    output logic       brake,
    output logic       acc,
    output logic       RG,
    output logic [1:0] s,
    output logic       busy,
    output logic       grant_id,
    output logic       err
);

    localparam int unsigned CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_STOP  = 3'd2;
    localparam logic [2:0] CMD_ACCEL = 3'd3;
    localparam logic [2:0] CMD_BRAKE = 3'd4;
    localparam logic [2:0] CMD_LEFT  = 3'd5;
    localparam logic [2:0] CMD_RIGHT = 3'd6;
    localparam logic [2:0] CMD_REV   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          stop_pend;

    logic          sf_fire;
    logic          rc_fire;
    logic [2:0]    req_cmd;
    logic          d_reject;
    logic          d_drive;
    logic          d_brake;
    logic          d_acc;
    logic          d_rg;
    logic [1:0]    d_s;

    // Handshake readiness: safety wins in IDLE, may only preempt remote with BRAKE/STOP.
    always_comb begin
        sf_ready = 1'b0;
        rc_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                sf_ready = 1'b1;
                rc_ready = ~sf_valid;
            end
            ST_DRIVE: begin
                if (!grant_id) begin
                    sf_ready = (sf_cmd == CMD_BRAKE) || (sf_cmd == CMD_STOP);
                end
            end
            default: ;
        endcase
    end

    assign sf_fire = sf_valid & sf_ready;
    assign rc_fire = rc_valid & rc_ready;

    // Decode of the command being transferred this cycle.
    always_comb begin
        req_cmd  = sf_fire ? sf_cmd : rc_cmd;
        d_reject = (req_cmd >= CMD_ACCEL) && !key;
        d_drive  = (req_cmd != CMD_NOP) && !d_reject;
        d_brake  = (req_cmd == CMD_STOP) || (req_cmd == CMD_BRAKE);
        d_acc    = (req_cmd == CMD_ACCEL);
        d_rg     = (req_cmd == CMD_REV);
        d_s      = 2'd0;
        if (req_cmd == CMD_LEFT) begin
            d_s = 2'd2;
        end else if (req_cmd == CMD_RIGHT) begin
            d_s = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stop_pend <= 1'b0;
            key       <= 1'b0;
            brake     <= 1'b0;
            acc       <= 1'b0;
            RG        <= 1'b0;
            s         <= 2'd0;
            busy      <= 1'b0;
            grant_id  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sf_fire || rc_fire) begin
                        if (d_reject) begin
                            err <= 1'b1;
                        end else if (d_drive) begin
                            state     <= ST_DRIVE;
                            cnt       <= CW'(HOLD);
                            busy      <= 1'b1;
                            grant_id  <= sf_fire;
                            stop_pend <= (req_cmd == CMD_STOP);
                            brake     <= d_brake;
                            acc       <= d_acc;
                            RG        <= d_rg;
                            s         <= d_s;
                            if (req_cmd == CMD_START) begin
                                key <= 1'b1;
                            end
                        end
                    end
                end
                ST_DRIVE: begin
                    if (sf_fire) begin
                        // Preemption swaps outputs in one edge, restarting the hold window.
                        cnt       <= CW'(HOLD);
                        grant_id  <= 1'b1;
                        stop_pend <= (req_cmd == CMD_STOP);
                        brake     <= d_brake;
                        acc       <= d_acc;
                        RG        <= d_rg;
                        s         <= d_s;
                    end else if (cnt == CW'(1)) begin
                        brake     <= 1'b0;
                        acc       <= 1'b0;
                        RG        <= 1'b0;
                        s         <= 2'd0;
                        stop_pend <= 1'b0;
                        if (stop_pend) begin
                            key <= 1'b0;
                        end
                        if (GAP > 0) begin
                            state <= ST_GAP;
                            cnt   <= CW'(GAP);
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt <= CW'(1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Self-checking bench for drive_cmd_arbiter: timeline model of accepted commands
// compared every negedge, plus directed scenarios with literal expectations.
module tb_drive_cmd_arbiter;

    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       rc_valid = 1'b0;
    logic [2:0] rc_cmd = 3'd0;
    logic       rc_ready;
    logic       sf_valid = 1'b0;
    logic [2:0] sf_cmd = 3'd0;
    logic       sf_ready;
    logic       key, brake, acc, RG, busy, grant_id, err;
    logic [1:0] s;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model: the last accepted command and the edge it was accepted at.
    logic       m_have = 1'b0;
    int         m_k = 0;
    logic [2:0] m_cmd = 3'd0;
    logic       m_key = 1'b0;
    logic       m_grant = 1'b0;
    logic       m_err = 1'b0;

    drive_cmd_arbiter #(.HOLD(HOLD), .GAP(GAP)) dut (
        .clk(clk), .clr_n(clr_n),
        .rc_valid(rc_valid), .rc_cmd(rc_cmd), .rc_ready(rc_ready),
        .sf_valid(sf_valid), .sf_cmd(sf_cmd), .sf_ready(sf_ready),
        .key(key), .brake(brake), .acc(acc), .RG(RG), .s(s),
        .busy(busy), .grant_id(grant_id), .err(err)
    );

    always #5 clk = ~clk;

    // 0 idle, 1 drive, 2 gap for the cycle following edge e.
    function automatic int phase_at(int e);
        if (!m_have) return 0;
        if (e >= m_k + HOLD + GAP) return 0;
        if (e >= m_k + HOLD) return 2;
        return 1;
    endfunction

    function automatic logic [1:0] exp_ready();
        int ph;
        ph = phase_at(cyc);
        if (ph == 0) return {~sf_valid, 1'b1};
        if (ph == 1 && !m_grant) return {1'b0, (sf_cmd == 3'd2) || (sf_cmd == 3'd4)};
        return 2'b00;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_have  = 1'b0;
            m_key   = 1'b0;
            m_grant = 1'b0;
            m_err   = 1'b0;
        end else begin : model_step
            logic [1:0] r;
            logic       rf, sfe;
            logic [2:0] c;
            int         ph;
            ph  = phase_at(cyc);
            r   = exp_ready();
            rf  = rc_valid & r[1];
            sfe = sf_valid & r[0];
            c   = sfe ? sf_cmd : rc_cmd;
            cyc = cyc + 1;
            m_err = 1'b0;
            if (ph == 0 && (rf || sfe)) begin
                if (c != 3'd0) begin
                    if (c >= 3'd3 && !m_key) begin
                        m_err = 1'b1;
                    end else begin
                        m_have  = 1'b1;
                        m_k     = cyc;
                        m_cmd   = c;
                        m_grant = sfe;
                        if (c == 3'd1) m_key = 1'b1;
                    end
                end
            end else if (ph == 1 && sfe) begin
                m_k     = cyc;
                m_cmd   = c;
                m_grant = 1'b1;
            end else if (ph == 1 && cyc == m_k + HOLD && m_cmd == 3'd2) begin
                m_key = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [10:0] got, want;
        logic [1:0]  ws;
        logic [2:0]  c;
        int          ph;
        ph = phase_at(cyc);
        c  = m_cmd;
        ws = 2'd0;
        if (ph == 1 && c == 3'd5) ws = 2'd2;
        if (ph == 1 && c == 3'd6) ws = 2'd1;
        want = {exp_ready(), m_key, (ph == 1) && (c == 3'd2 || c == 3'd4),
                (ph == 1) && (c == 3'd3), (ph == 1) && (c == 3'd7), ws,
                ph != 0, m_grant, m_err};
        got  = {rc_ready, sf_ready, key, brake, acc, RG, s, busy, grant_id, err};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL cycle_outs @%0d: got %b want %b", cyc, got, want);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold valid until accepted; e is the edge count just before the accepting edge.
    task automatic send(input bit src, input logic [2:0] c, output int e);
        e = -1;
        if (src) begin sf_valid = 1'b1; sf_cmd = c; end
        else begin rc_valid = 1'b1; rc_cmd = c; end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((src ? sf_ready : rc_ready) === 1'b1) begin
                e = cyc;
                @(posedge clk);
                #1;
                break;
            end
        end
        if (src) sf_valid = 1'b0; else rc_valid = 1'b0;
        n_cmp++;
        if (e < 0) begin
            n_fail++;
            $display("FAIL handshake_timeout: src %0d got no accept want accept", src);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (busy === 1'b0) break;
            tick(1);
        end
        chk("idle_wait", int'(busy), 0);
    endtask

    initial begin
        int e1, e2, n;
        #2 clr_n = 1'b0;
        tick(2);
        chk("rst_key", int'(key), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_s", int'(s), 0);
        clr_n = 1'b1;
        chk("rst_sf_ready", int'(sf_ready), 1);
        chk("rst_rc_ready", int'(rc_ready), 1);
        tick(1);

        send(1'b0, 3'd1, e1);
        chk("start_key", int'(key), 1);
        chk("start_rc_ready", int'(rc_ready), 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) break;
            n++;
            tick(1);
        end
        chk("busy_len", n, HOLD + GAP);

        send(1'b0, 3'd3, e1);
        chk("accel_acc", int'(acc), 1);
        send(1'b0, 3'd3, e2);
        chk("accel_spacing", e2 - e1, HOLD + GAP + 1);
        wait_idle();

        rc_valid = 1'b1; rc_cmd = 3'd5;
        sf_valid = 1'b1; sf_cmd = 3'd4;
        @(negedge clk);
        chk("both_sf_ready", int'(sf_ready), 1);
        chk("both_rc_ready", int'(rc_ready), 0);
        e1 = cyc;
        @(posedge clk); #1;
        sf_valid = 1'b0;
        chk("both_brake", int'(brake), 1);
        chk("both_grant", int'(grant_id), 1);
        send(1'b0, 3'd5, e2);
        chk("left_spacing", e2 - e1, HOLD + GAP + 1);
        chk("left_s", int'(s), 2);
        chk("left_grant", int'(grant_id), 0);
        wait_idle();

        send(1'b0, 3'd3, e1);
        chk("pre_acc", int'(acc), 1);
        tick(1);
        sf_valid = 1'b1; sf_cmd = 3'd2;
        @(negedge clk);
        chk("preempt_ready", int'(sf_ready), 1);
        @(posedge clk); #1;
        chk("preempt_acc", int'(acc), 0);
        chk("preempt_brake", int'(brake), 1);
        chk("preempt_grant", int'(grant_id), 1);
        sf_cmd = 3'd4;
        @(negedge clk);
        chk("sf_on_sf_ready", int'(sf_ready), 0);
        @(posedge clk); #1;
        sf_valid = 1'b0;
        tick(2);
        chk("stop_brake_last", int'(brake), 1);
        chk("stop_key_last", int'(key), 1);
        tick(1);
        chk("stop_brake_end", int'(brake), 0);
        chk("stop_key_end", int'(key), 0);
        wait_idle();

        send(1'b0, 3'd7, e1);
        chk("rej_err", int'(err), 1);
        chk("rej_rg", int'(RG), 0);
        chk("rej_busy", int'(busy), 0);
        tick(1);
        chk("rej_err_clear", int'(err), 0);

        send(1'b1, 3'd0, e1);
        chk("sf_nop_err", int'(err), 0);
        chk("sf_nop_busy", int'(busy), 0);

        send(1'b0, 3'd1, e1);
        tick(3);
        sf_valid = 1'b1; sf_cmd = 3'd4;
        @(posedge clk); #1;
        sf_valid = 1'b0;
        chk("late_preempt_brake", int'(brake), 1);
        chk("late_preempt_busy", int'(busy), 1);
        chk("late_preempt_key", int'(key), 1);
        wait_idle();

        send(1'b0, 3'd6, e1);
        chk("right_s", int'(s), 1);
        tick(1);
        #2 clr_n = 1'b0;
        #1;
        chk("midrst_s", int'(s), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_key", int'(key), 0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        tick(1);
        send(1'b0, 3'd0, e1);
        chk("nop_err", int'(err), 0);
        chk("nop_busy", int'(busy), 0);
        tick(1);
        chk("nop_err_next", int'(err), 0);

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
